// File: rtl/hb_bus_pkg.sv
// Shared definitions for the 65C02 bus helpers (wait-state generation and
// future slow peripherals such as the VIA and LCD).
package hb_bus_pkg;

  // Wait-state FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Default stall counts per slow device, in whole CPU cycles
  localparam int ROM_WAIT_DEF  = 1;
  localparam int ACIA_WAIT_DEF = 2;

  // Default stall counter width (holds up to 15 stall cycles)
  localparam int CNT_W_DEF = 4;

  // Larger of two wait counts; used when the decoder asserts both selects
  function automatic int max_wait(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wait_state_gen_ws_counter.sv
// Loadable, saturating down-counter used to time a stall sequence.
// Load has priority over decrement; decrement stops at zero.
module ws_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         is_one
);

  logic [W-1:0] count_r;

  // Counter register: load, saturating decrement, or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= W'(1'b0);
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != W'(1'b0))) begin
      count_r <= count_r - W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count  = count_r;
  assign is_one = (count_r == W'(1'b1));

endmodule

// File: rtl/wait_state_gen.sv
// 65C02 RDY wait-state generator. Stretches each ROM or ACIA access by a
// programmable number of whole CPU cycles by pulling RDY low.
module wait_state_gen
  import hb_bus_pkg::*;
#(
  parameter int ROM_WAIT  = ROM_WAIT_DEF,
  parameter int ACIA_WAIT = ACIA_WAIT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic CS_ROM_B,
  input  logic CS_ACIA_B,
  input  logic RWB,
  input  logic WS_EN,
  output logic RDY,
  output logic WS_ACTIVE
);

  localparam logic [CNT_W-1:0] ROM_N  = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] ACIA_N = CNT_W'(ACIA_WAIT);
  localparam logic [CNT_W-1:0] MAX_N  = CNT_W'(max_wait(ROM_WAIT, ACIA_WAIT));

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             sel_rom_s;
  logic             sel_acia_s;
  logic             slow_sel_s;
  logic [CNT_W-1:0] n_s;
  logic [CNT_W-1:0] load_val_s;
  logic             start_s;
  logic             rdy_s;
  logic             load_s;
  logic             dec_s;
  logic [CNT_W-1:0] count_s;
  logic             is_one_s;
  logic             rwb_unused_s;

  // Stalls apply to reads and writes alike, so the direction is not needed
  assign rwb_unused_s = RWB;

  assign sel_rom_s  = ~CS_ROM_B;
  assign sel_acia_s = ~CS_ACIA_B;
  assign slow_sel_s = WS_EN & (sel_rom_s | sel_acia_s);

  // Stall length for the device currently selected; dual select takes the longer
  always_comb begin
    n_s = CNT_W'(1'b0);
    case ({sel_rom_s, sel_acia_s})
      2'b11:   n_s = MAX_N;
      2'b10:   n_s = ROM_N;
      2'b01:   n_s = ACIA_N;
      default: n_s = CNT_W'(1'b0);
    endcase
  end

  assign start_s    = slow_sel_s && (n_s != CNT_W'(1'b0));
  assign load_val_s = n_s - CNT_W'(1'b1);

  // Next-state, RDY and counter control; RDY depends on selects only in IDLE
  always_comb begin
    state_nxt_s = ST_IDLE;
    rdy_s       = 1'b1;
    load_s      = 1'b0;
    dec_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          rdy_s  = 1'b0;
          load_s = 1'b1;
          if (n_s > CNT_W'(1'b1)) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_RELEASE;
          end
        end else begin
          rdy_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        rdy_s = 1'b0;
        dec_s = 1'b1;
        if (is_one_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RELEASE: begin
        rdy_s       = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        rdy_s       = 1'b1;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset returns to IDLE without waiting for a clock
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  ws_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (load_s),
    .dec      (dec_s),
    .load_val (load_val_s),
    .count    (count_s),
    .is_one   (is_one_s)
  );

  // While reset is held the selects may still be low; force RDY high anyway
  assign RDY       = RST | rdy_s;
  assign WS_ACTIVE = (state_r != ST_IDLE);

endmodule

// File: tb/tb_wait_state_gen.sv
// Scoreboard bench for wait_state_gen: four instances with different wait
// counts share one stimulus stream; a behavioural model pushes the expected
// RDY/WS_ACTIVE per cycle and the negedge checker pops and compares.
module tb_wait_state_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_rom_b;
  logic       cs_acia_b;
  logic       rwb;
  logic       ws_en;
  logic [3:0] rdy;
  logic [3:0] act;

  int total = 0;
  int bad   = 0;

  // Instance parameters: {ROM_WAIT, ACIA_WAIT}
  int rom_w  [4] = '{1, 3, 0, 1};
  int acia_w [4] = '{2, 2, 2, 3};

  // Model state per instance: 0 idle, 1 stalling, 2 release
  int m_phase [4] = '{0, 0, 0, 0};
  int m_left  [4] = '{0, 0, 0, 0};

  // Expected {act[3:0], rdy[3:0]} per driven cycle
  logic [7:0] exp_q[$];

  // Free-running CPU clock
  always #5 clk = ~clk;

  wait_state_gen #(.ROM_WAIT(1), .ACIA_WAIT(2), .CNT_W(4)) d0 (
    .CLK(clk), .RST(rst), .CS_ROM_B(cs_rom_b), .CS_ACIA_B(cs_acia_b),
    .RWB(rwb), .WS_EN(ws_en), .RDY(rdy[0]), .WS_ACTIVE(act[0]));
  wait_state_gen #(.ROM_WAIT(3), .ACIA_WAIT(2), .CNT_W(4)) d1 (
    .CLK(clk), .RST(rst), .CS_ROM_B(cs_rom_b), .CS_ACIA_B(cs_acia_b),
    .RWB(rwb), .WS_EN(ws_en), .RDY(rdy[1]), .WS_ACTIVE(act[1]));
  wait_state_gen #(.ROM_WAIT(0), .ACIA_WAIT(2), .CNT_W(4)) d2 (
    .CLK(clk), .RST(rst), .CS_ROM_B(cs_rom_b), .CS_ACIA_B(cs_acia_b),
    .RWB(rwb), .WS_EN(ws_en), .RDY(rdy[2]), .WS_ACTIVE(act[2]));
  wait_state_gen #(.ROM_WAIT(1), .ACIA_WAIT(3), .CNT_W(4)) d3 (
    .CLK(clk), .RST(rst), .CS_ROM_B(cs_rom_b), .CS_ACIA_B(cs_acia_b),
    .RWB(rwb), .WS_EN(ws_en), .RDY(rdy[3]), .WS_ACTIVE(act[3]));

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: expected outputs for this cycle, then advance
  task automatic model_cycle(input logic rb, input logic ab, input logic en,
                             output logic [7:0] e);
    e = 8'h00;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      if (!rb && !ab)  n = (rom_w[i] > acia_w[i]) ? rom_w[i] : acia_w[i];
      else if (!rb)    n = rom_w[i];
      else if (!ab)    n = acia_w[i];
      case (m_phase[i])
        0: begin
          e[4+i] = 1'b0;
          if (en && n > 0) begin
            e[i] = 1'b0;
            if (n > 1) begin
              m_phase[i] = 1;
              m_left[i]  = n - 1;
            end else begin
              m_phase[i] = 2;
            end
          end else begin
            e[i] = 1'b1;
          end
        end
        1: begin
          e[i]   = 1'b0;
          e[4+i] = 1'b1;
          m_left[i]--;
          if (m_left[i] == 0) m_phase[i] = 2;
        end
        default: begin
          e[i]       = 1'b1;
          e[4+i]     = 1'b1;
          m_phase[i] = 0;
        end
      endcase
    end
  endtask

  // One CPU cycle: drive inputs just after the rising edge, push expectation
  task automatic cyc(input logic rb, input logic ab, input logic rw, input logic en);
    logic [7:0] e;
    @(posedge clk);
    #1;
    cs_rom_b  = rb;
    cs_acia_b = ab;
    rwb       = rw;
    ws_en     = en;
    model_cycle(rb, ab, en, e);
    exp_q.push_back(e);
  endtask

  // Scoreboard checker: compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("rdy", {4'd0, rdy}, {4'd0, e[3:0]});
      check_val("ws_active", {4'd0, act}, {4'd0, e[7:4]});
    end
  end

  initial begin
    rst       = 1'b1;
    cs_rom_b  = 1'b1;
    cs_acia_b = 1'b1;
    rwb       = 1'b1;
    ws_en     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_rdy", {4'd0, rdy}, 8'h0F);
    check_val("reset_act", {4'd0, act}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b1);

    // ROM read; the select drops during d1's WAIT and must be ignored
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b1);

    // ACIA write
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b1);

    // Back-to-back ROM fetches
    repeat (8) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b1);

    // Disabled: ACIA select must not stall
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b1);

    // Enable drops mid-sequence: current sequence completes, no restart
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b1);

    // Illegal dual select stalls for the longer count
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b1);

    // Async reset in d1's second stall cycle (ROM_WAIT=3)
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_val("pre_reset_rdy1", {7'd0, rdy[1]}, 8'h00);
    check_val("pre_reset_act1", {7'd0, act[1]}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_reset_rdy", {4'd0, rdy}, 8'h0F);
    check_val("async_reset_act", {4'd0, act}, 8'h00);
    cs_rom_b = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_phase[i] = 0;
      m_left[i]  = 0;
    end
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b1);

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      check_val("queue_drained", 8'(exp_q.size()), 8'h00);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
